// File: rtl/div_clk_multi.sv
// div_clk_multi: NCH key-programmable clock dividers, +/-STEP clamped to [DIV_MIN,DIV_MAX]; DIV_CLK_MULTI_TICK_EN adds o_tick.
// Latency: divisor readback 1 cycle after the strobe, takes effect at the next period wrap; no backpressure (events never stall).
module div_clk_multi #(
  parameter int NCH      = 2,
  parameter int CH_W     = 1,
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 200,
  parameter int STEP     = 100,
  parameter int DIV_MIN  = 2,
  parameter int DIV_MAX  = 65000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_key_val,
  input  logic [1:0]           i_key,
  input  logic [CH_W-1:0]      i_ch_sel,
  input  logic [NCH-1:0]       i_en,
  output logic [NCH-1:0]       o_div_clk,
  output logic [NCH*DIV_W-1:0] o_div_num,
`ifdef DIV_CLK_MULTI_TICK_EN
  output logic [NCH-1:0]       o_tick,
`endif
  output logic                 o_sat
);

  localparam int AW = DIV_W + 1;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW-1:0] MAX_A  = AW'(DIV_MAX);
  localparam logic [AW-1:0] LOW_A  = AW'(DIV_MIN + STEP);

  logic [31:0]      sel_idx;
  logic             sel_ok;
  logic [DIV_W-1:0] cur_d;
  logic [DIV_W-1:0] new_d;
  logic [AW-1:0]    cur_w;
  logic [AW-1:0]    inc_w;
  logic             upd;
  logic             clamp;

  assign sel_idx = 32'(i_ch_sel);
  assign sel_ok  = sel_idx < NCH;

  // One shared adder path serves whichever channel the event targets.
  always_comb begin
    cur_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_idx == k) cur_d = o_div_num[k*DIV_W +: DIV_W];
    end
    cur_w = {1'b0, cur_d};
    inc_w = cur_w + STEP_A;
    new_d = cur_d;
    upd   = 1'b0;
    clamp = 1'b0;
    if (i_key_val && sel_ok) begin
      case (i_key)
        2'b01: begin
          upd = 1'b1;
          if (inc_w > MAX_A) begin
            new_d = DIV_W'(DIV_MAX);
            clamp = 1'b1;
          end else begin
            new_d = inc_w[DIV_W-1:0];
          end
        end
        2'b10: begin
          upd = 1'b1;
          if (cur_w < LOW_A) begin
            new_d = DIV_W'(DIV_MIN);
            clamp = 1'b1;
          end else begin
            new_d = cur_d - DIV_W'(STEP);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) o_sat <= 1'b0;
    else       o_sat <= clamp;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] cnt;
    logic             clk_r;
    logic             hit;
    logic             wrap;

    assign hit  = upd && (sel_idx == k);
    assign wrap = (cnt == act - DIV_W'(1));

    always_ff @(posedge clk) begin
      if (!rstn) begin
        div_r <= DIV_W'(DIV_INIT);
        act   <= DIV_W'(DIV_INIT);
        cnt   <= '0;
        clk_r <= 1'b0;
      end else begin
        if (hit) div_r <= new_d;
        // act only follows div_r at a period boundary (or while idle), so no runt pulses.
        if (i_en[k]) begin
          if (wrap) begin
            cnt <= '0;
            act <= div_r;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
          clk_r <= (cnt < (act >> 1));
        end else begin
          cnt   <= '0;
          act   <= div_r;
          clk_r <= 1'b0;
        end
      end
    end

    assign o_div_clk[k]                 = clk_r;
    assign o_div_num[k*DIV_W +: DIV_W]  = div_r;

`ifdef DIV_CLK_MULTI_TICK_EN
    logic wrap_q;
    logic tick_r;

    // Two stages so the tick lines up with the o_div_clk rising edge.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        wrap_q <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        wrap_q <= i_en[k] & wrap;
        tick_r <= i_en[k] & wrap_q;
      end
    end

    assign o_tick[k] = tick_r;
`endif
  end

endmodule

// File: tb/tb_div_clk_multi.sv
// Directed bench for div_clk_multi with small divisors (init 9, step 3, bounds 3..15) to keep periods short.
module tb_div_clk_multi;

  localparam int NCH = 2;
  localparam int CH_W = 2;
  localparam int DIV_W = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 i_key_val;
  logic [1:0]           i_key;
  logic [CH_W-1:0]      i_ch_sel;
  logic [NCH-1:0]       i_en;
  logic [NCH-1:0]       o_div_clk;
  logic [NCH*DIV_W-1:0] o_div_num;
  logic                 o_sat;
`ifdef DIV_CLK_MULTI_TICK_EN
  logic [NCH-1:0]       o_tick;
`endif

  div_clk_multi #(
    .NCH(NCH), .CH_W(CH_W), .DIV_W(DIV_W), .DIV_INIT(9),
    .STEP(3), .DIV_MIN(3), .DIV_MAX(15)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_key_val(i_key_val),
    .i_key(i_key),
    .i_ch_sel(i_ch_sel),
    .i_en(i_en),
    .o_div_clk(o_div_clk),
    .o_div_num(o_div_num),
`ifdef DIV_CLK_MULTI_TICK_EN
    .o_tick(o_tick),
`endif
    .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the cycle stamp of the next transition of o_div_clk[ch] to lvl.
  task automatic wait_edge(input int ch, input logic lvl, output int t);
    logic prev;
    bit   found;
    prev  = o_div_clk[ch];
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (prev !== lvl && o_div_clk[ch] === lvl) begin
        found = 1'b1;
        t     = cyc;
      end
      prev = o_div_clk[ch];
    end
    if (!found) chk($sformatf("edge_timeout_ch%0d", ch), 32'(found), 1);
  endtask

  task automatic key(input logic [1:0] code, input logic [CH_W-1:0] sel);
    i_key_val = 1'b1;
    i_key     = code;
    i_ch_sel  = sel;
    @(negedge clk);
    i_key_val = 1'b0;
    i_key     = 2'b00;
    i_ch_sel  = '0;
  endtask

  task automatic measure(input int ch, input string tag, input int hi_exp, input int per_exp);
    int t0, t1, t2;
    wait_edge(ch, 1'b1, t0);
    wait_edge(ch, 1'b0, t1);
    wait_edge(ch, 1'b1, t2);
    chk({tag, "_hi"}, 32'(t1 - t0), 32'(hi_exp));
    chk({tag, "_per"}, 32'(t2 - t0), 32'(per_exp));
  endtask

  initial begin
    int t0, t1, t2;
    rstn = 1'b0; i_key_val = 1'b0; i_key = 2'b00; i_ch_sel = '0; i_en = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_clk", 32'(o_div_clk), 0);
    chk("rst_num", 32'(o_div_num), {16'd0, 8'd9, 8'd9});
    chk("rst_sat", 32'(o_sat), 0);

    rstn = 1'b1;
    i_en = 2'b11;
    measure(0, "init_ch0", 4, 9);
    measure(1, "init_ch1", 4, 9);

    // Increase ch0 mid-period: current period keeps length 9, later ones are 12.
    wait_edge(0, 1'b1, t0);
    repeat (2) @(negedge clk);
    key(2'b01, 2'd0);
    chk("inc_num0", 32'(o_div_num[7:0]), 12);
    chk("inc_num1", 32'(o_div_num[15:8]), 9);
    chk("inc_sat", 32'(o_sat), 0);
    wait_edge(0, 1'b1, t1);
    chk("inc_old_per", 32'(t1 - t0), 9);
    wait_edge(0, 1'b0, t2);
    chk("inc_new_hi", 32'(t2 - t1), 6);
    wait_edge(0, 1'b1, t2);
    chk("inc_new_per", 32'(t2 - t1), 12);

    // Upper clamp on ch1.
    key(2'b01, 2'd1);
    chk("max1_num", 32'(o_div_num[15:8]), 12); chk("max1_sat", 32'(o_sat), 0);
    key(2'b01, 2'd1);
    chk("max2_num", 32'(o_div_num[15:8]), 15); chk("max2_sat", 32'(o_sat), 0);
    key(2'b01, 2'd1);
    chk("max3_num", 32'(o_div_num[15:8]), 15); chk("max3_sat", 32'(o_sat), 1);
    @(negedge clk);
    chk("max_sat_drop", 32'(o_sat), 0);

    // Lower clamp on ch0: 12 -> 9 -> 6 -> 3 -> 3 (clamped).
    key(2'b10, 2'd0);
    chk("min1_num", 32'(o_div_num[7:0]), 9); chk("min1_sat", 32'(o_sat), 0);
    key(2'b10, 2'd0);
    chk("min2_num", 32'(o_div_num[7:0]), 6); chk("min2_sat", 32'(o_sat), 0);
    key(2'b10, 2'd0);
    chk("min3_num", 32'(o_div_num[7:0]), 3); chk("min3_sat", 32'(o_sat), 0);
    key(2'b10, 2'd0);
    chk("min4_num", 32'(o_div_num[7:0]), 3); chk("min4_sat", 32'(o_sat), 1);

    // No-op codes and out-of-range channel selects.
    key(2'b11, 2'd0);
    chk("nop11_num", 32'(o_div_num), {16'd0, 8'd15, 8'd3}); chk("nop11_sat", 32'(o_sat), 0);
    key(2'b00, 2'd1);
    chk("nop00_num", 32'(o_div_num), {16'd0, 8'd15, 8'd3});
    key(2'b01, 2'd2);
    chk("sel2_num", 32'(o_div_num), {16'd0, 8'd15, 8'd3}); chk("sel2_sat", 32'(o_sat), 0);
    key(2'b10, 2'd3);
    chk("sel3_num", 32'(o_div_num), {16'd0, 8'd15, 8'd3}); chk("sel3_sat", 32'(o_sat), 0);

    // Let the new divisors reach the active registers, then check odd-period duty.
    wait_edge(0, 1'b1, t0);
    wait_edge(0, 1'b1, t0);
    measure(0, "div3", 1, 3);
    wait_edge(1, 1'b1, t0);
    wait_edge(1, 1'b1, t0);
    measure(1, "div15", 7, 15);

    // Drop enable mid-high, then re-enable.
    wait_edge(0, 1'b1, t0);
    i_en[0] = 1'b0;
    @(negedge clk);
    chk("dis_next", 32'(o_div_clk[0]), 0);
    repeat (3) @(negedge clk);
    chk("dis_hold", 32'(o_div_clk[0]), 0);
    i_en[0] = 1'b1;
    @(negedge clk);
    chk("reen_c0", 32'(o_div_clk[0]), 1);
    @(negedge clk);
    chk("reen_c1", 32'(o_div_clk[0]), 0);
    @(negedge clk);
    chk("reen_c2", 32'(o_div_clk[0]), 0);
    @(negedge clk);
    chk("reen_c3", 32'(o_div_clk[0]), 1);

    // Reset in the middle of a high phase.
    wait_edge(1, 1'b1, t0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_clk", 32'(o_div_clk), 0);
    chk("mid_rst_num", 32'(o_div_num), {16'd0, 8'd9, 8'd9});
    chk("mid_rst_sat", 32'(o_sat), 0);
    rstn = 1'b1;
`ifdef DIV_CLK_MULTI_TICK_EN
    chk("tick_rst", 32'(o_tick), 0);
    wait_edge(0, 1'b1, t0);
    chk("tick_first", 32'(o_tick[0]), 0);
    wait_edge(0, 1'b1, t1);
    chk("tick_align", 32'(o_tick[0]), 1);
    chk("tick_per", 32'(t1 - t0), 9);
    @(negedge clk);
    chk("tick_drop", 32'(o_tick[0]), 0);
`endif
    measure(0, "post_rst", 4, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
